// File: rtl/labft_checksum_accumulator.sv
// Output-side checksum generator for the LABFT systolic array: folds each
// N x N tile of C into four weighted sums (w, x, y, z) with a one-cycle strobe.
module labft_checksum_accumulator #(
  parameter int unsigned arraySize    = 4,
  parameter int unsigned inputBits    = 8,
  parameter int unsigned addressWidth = (arraySize > 1) ? $clog2(arraySize) : 1,
  parameter int unsigned elemWidth    = 2*inputBits + $clog2(arraySize),
  parameter int unsigned accWidth     = 2*inputBits + 3*arraySize
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_row,
  input  logic [arraySize*elemWidth-1:0] row_data,
  output logic                          valid_acc,
  output logic [accWidth-1:0]           w_acc,
  output logic [accWidth-1:0]           x_acc,
  output logic [accWidth-1:0]           y_acc,
  output logic [accWidth-1:0]           z_acc
);

  localparam int unsigned CntW = addressWidth;

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [accWidth-1:0] w_q, x_q, y_q, z_q;
  logic [accWidth-1:0] w_acc_q, x_acc_q, y_acc_q, z_acc_q;
  logic                valid_acc_q;

  logic [accWidth-1:0] elem_c, rs_c, rc_c, r_c;
  logic [accWidth-1:0] w_d, x_d, y_d, z_d;
  logic                last_c;

  // Row reductions and next partial sums; IDLE starts from zero so stale sums never leak.
  always_comb begin
    elem_c = '0;
    rs_c   = '0;
    rc_c   = '0;
    for (int c = 0; c < arraySize; c++) begin
      elem_c = accWidth'(row_data[c*elemWidth +: elemWidth]);
      rs_c   = rs_c + elem_c;
      rc_c   = rc_c + accWidth'(c) * elem_c;
    end
    r_c    = (state_q == IDLE) ? '0 : accWidth'(cnt_q);
    w_d    = ((state_q == IDLE) ? '0 : w_q) + rs_c;
    x_d    = ((state_q == IDLE) ? '0 : x_q) + r_c * rs_c;
    y_d    = ((state_q == IDLE) ? '0 : y_q) + rc_c;
    z_d    = ((state_q == IDLE) ? '0 : z_q) + r_c * rc_c;
    last_c = (state_q == IDLE) ? (arraySize == 1) : (cnt_q == CntW'(arraySize - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      w_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      w_acc_q     <= '0;
      x_acc_q     <= '0;
      y_acc_q     <= '0;
      z_acc_q     <= '0;
      valid_acc_q <= 1'b0;
    end else begin
      valid_acc_q <= 1'b0;
      if (valid_row) begin
        if (last_c) begin
          w_acc_q     <= w_d;
          x_acc_q     <= x_d;
          y_acc_q     <= y_d;
          z_acc_q     <= z_d;
          valid_acc_q <= 1'b1;
          cnt_q       <= '0;
          state_q     <= IDLE;
        end else begin
          w_q     <= w_d;
          x_q     <= x_d;
          y_q     <= y_d;
          z_q     <= z_d;
          cnt_q   <= cnt_q + CntW'(1);
          state_q <= ACCUM;
        end
      end
    end
  end

  assign valid_acc = valid_acc_q;
  assign w_acc     = w_acc_q;
  assign x_acc     = x_acc_q;
  assign y_acc     = y_acc_q;
  assign z_acc     = z_acc_q;

endmodule

// File: tb/tb_labft_checksum_accumulator.sv
// Directed bench for labft_checksum_accumulator (N=4): hand-computed tile checksums.
module tb_labft_checksum_accumulator;

  localparam int unsigned N    = 4;
  localparam int unsigned EW   = 18;
  localparam int unsigned AW   = 28;
  localparam int unsigned RW   = N*EW;
  localparam logic [AW-1:0] M  = AW'(262143);

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_row;
  logic [RW-1:0] row_data;
  logic          valid_acc;
  logic [AW-1:0] w_acc, x_acc, y_acc, z_acc;

  int n_vec = 0;
  int n_err = 0;

  labft_checksum_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .valid_row (valid_row),
    .row_data  (row_data),
    .valid_acc (valid_acc),
    .w_acc     (w_acc),
    .x_acc     (x_acc),
    .y_acc     (y_acc),
    .z_acc     (z_acc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [AW-1:0] w, input logic [AW-1:0] x,
                         input logic [AW-1:0] y, input logic [AW-1:0] z);
    chk({tag, ".w"}, w_acc, w);
    chk({tag, ".x"}, x_acc, x);
    chk({tag, ".y"}, y_acc, y);
    chk({tag, ".z"}, z_acc, z);
  endtask

  function automatic logic [RW-1:0] ones_row();
    logic [RW-1:0] d = '0;
    for (int c = 0; c < N; c++) d[c*EW +: EW] = EW'(1);
    return d;
  endfunction

  function automatic logic [RW-1:0] id_row(input int r);
    logic [RW-1:0] d = '0;
    d[r*EW +: EW] = EW'(1);
    return d;
  endfunction

  task automatic send(input logic [RW-1:0] d);
    valid_row = 1'b1;
    row_data  = d;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    valid_row = 1'b0;
    row_data  = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset.valid", AW'(valid_acc), '0);
    chk_out("reset", '0, '0, '0, '0);

    // Idle with no rows: nothing moves
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle.valid", AW'(valid_acc), '0);
    end
    chk_out("idle", '0, '0, '0, '0);

    // All-ones tile, consecutive rows
    for (int i = 0; i < N; i++) begin
      send(ones_row());
      if (i < N-1) chk("ones.early", AW'(valid_acc), '0);
    end
    valid_row = 1'b0;
    chk("ones.strobe", AW'(valid_acc), AW'(1));
    chk_out("ones", AW'(16), AW'(24), AW'(24), AW'(36));
    tick();
    chk("ones.pulse1", AW'(valid_acc), '0);
    chk_out("ones.hold", AW'(16), AW'(24), AW'(24), AW'(36));

    // Identity tile with 2-cycle gaps between rows
    for (int r = 0; r < N; r++) begin
      send(id_row(r));
      valid_row = 1'b0;
      if (r < N-1) begin
        chk("gap.early", AW'(valid_acc), '0);
        tick();
        tick();
        chk("gap.idle", AW'(valid_acc), '0);
        chk("gap.hold", w_acc, AW'(16));
      end
    end
    chk("gap.strobe", AW'(valid_acc), AW'(1));
    chk_out("gap", AW'(4), AW'(6), AW'(14 - 8), AW'(14));

    tick();
    // Back-to-back: ones then identity, no bubble; strobes at cycles 5 and 9
    for (int i = 0; i < 2*N; i++) begin
      send((i < N) ? ones_row() : id_row(i - N));
      if (i == N-1) begin
        chk("b2b.strobe1", AW'(valid_acc), AW'(1));
        chk_out("b2b.t1", AW'(16), AW'(24), AW'(24), AW'(36));
      end else if (i == 2*N-1) begin
        chk("b2b.strobe2", AW'(valid_acc), AW'(1));
        chk_out("b2b.t2", AW'(4), AW'(6), AW'(6), AW'(14));
      end else begin
        chk("b2b.nostrobe", AW'(valid_acc), '0);
        if (i > N-1) chk("b2b.hold", z_acc, AW'(36));
      end
    end
    valid_row = 1'b0;
    tick();
    chk("b2b.after", AW'(valid_acc), '0);

    // Reset mid-tile, with valid_row asserted during reset
    send(ones_row());
    send(ones_row());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    valid_row = 1'b0;
    chk("midrst.valid", AW'(valid_acc), '0);
    chk_out("midrst", '0, '0, '0, '0);
    for (int r = 0; r < N; r++) begin
      send(id_row(r));
      if (r < N-1) chk("midrst.early", AW'(valid_acc), '0);
    end
    valid_row = 1'b0;
    chk("midrst.strobe", AW'(valid_acc), AW'(1));
    chk_out("midrst.tile", AW'(4), AW'(6), AW'(6), AW'(14));
    tick();

    // All elements at max value
    for (int r = 0; r < N; r++) send('1);
    valid_row = 1'b0;
    chk("max.strobe", AW'(valid_acc), AW'(1));
    chk_out("max", AW'(16) * M, AW'(24) * M, AW'(24) * M, AW'(36) * M);
    tick();
    chk("max.pulse1", AW'(valid_acc), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
